// File: rtl/dm_jtag_dtm.sv
// JTAG Debug Transport Module: 5-bit-IR TAP sampled in the clk domain, turning DMI
// Update-DR scans into dmi_valid/dmi_ready requests toward the debug module.
module dm_jtag_dtm #(
    parameter logic [31:0] IDCODE = 32'h1000_0A6D,
    parameter int unsigned ABITS  = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tck,
    input  logic             tms,
    input  logic             tdi,
    output logic             tdo,
    output logic             dmi_valid,
    input  logic             dmi_ready,
    output logic             dmi_write,
    output logic [ABITS-1:0] dmi_addr,
    output logic [31:0]      dmi_wdata,
    input  logic [31:0]      dmi_rdata
);

    localparam int unsigned DRW       = ABITS + 34;
    localparam logic [4:0]  IR_IDCODE = 5'h01;
    localparam logic [4:0]  IR_DTMCS  = 5'h10;
    localparam logic [4:0]  IR_DMI    = 5'h11;

    typedef enum logic [3:0] {
        TLR, RTI,
        SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
    } tap_state_t;

    logic             tck_meta_r, tck_sync_r, tck_prev_r;
    logic             tms_meta_r, tms_sync_r;
    logic             tdi_meta_r, tdi_sync_r;
    tap_state_t       state_r;
    logic [4:0]       ir_r, ir_shift_r;
    logic [DRW-1:0]   dr_r;
    logic             tdo_r;
    logic             dmi_valid_r, dmi_write_r, busy_r;
    logic [ABITS-1:0] dmi_addr_r;
    logic [31:0]      dmi_wdata_r, rdata_buf_r;
    logic [1:0]       dmistat_r;

    logic             tck_rise_s, tck_fall_s, upd_dr_s, dmi_req_s, dtmcs_clear_s;
    logic [DRW-1:0]   dr_capture_s, dr_shift_s;

    function automatic tap_state_t tap_next(input tap_state_t s, input logic m);
        case (s)
            TLR:     tap_next = m ? TLR    : RTI;
            RTI:     tap_next = m ? SEL_DR : RTI;
            SEL_DR:  tap_next = m ? SEL_IR : CAP_DR;
            CAP_DR:  tap_next = m ? EX1_DR : SH_DR;
            SH_DR:   tap_next = m ? EX1_DR : SH_DR;
            EX1_DR:  tap_next = m ? UPD_DR : PAU_DR;
            PAU_DR:  tap_next = m ? EX2_DR : PAU_DR;
            EX2_DR:  tap_next = m ? UPD_DR : SH_DR;
            UPD_DR:  tap_next = m ? SEL_DR : RTI;
            SEL_IR:  tap_next = m ? TLR    : CAP_IR;
            CAP_IR:  tap_next = m ? EX1_IR : SH_IR;
            SH_IR:   tap_next = m ? EX1_IR : SH_IR;
            EX1_IR:  tap_next = m ? UPD_IR : PAU_IR;
            PAU_IR:  tap_next = m ? EX2_IR : PAU_IR;
            EX2_IR:  tap_next = m ? UPD_IR : SH_IR;
            UPD_IR:  tap_next = m ? SEL_DR : RTI;
            default: tap_next = TLR;
        endcase
    endfunction

    // Two-flop synchronisers for the TAP pins plus a history flop for tck edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            tck_meta_r <= 1'b0;
            tck_sync_r <= 1'b0;
            tck_prev_r <= 1'b0;
            tms_meta_r <= 1'b0;
            tms_sync_r <= 1'b0;
            tdi_meta_r <= 1'b0;
            tdi_sync_r <= 1'b0;
        end else begin
            tck_meta_r <= tck;
            tck_sync_r <= tck_meta_r;
            tck_prev_r <= tck_sync_r;
            tms_meta_r <= tms;
            tms_sync_r <= tms_meta_r;
            tdi_meta_r <= tdi;
            tdi_sync_r <= tdi_meta_r;
        end
    end

    // Edge strobes, DR capture/shift values and Update-DR side effects
    always_comb begin
        tck_rise_s = tck_sync_r & ~tck_prev_r;
        tck_fall_s = ~tck_sync_r & tck_prev_r;
        upd_dr_s   = tck_rise_s && (state_r == UPD_DR);
        dmi_req_s  = upd_dr_s && (ir_r == IR_DMI) &&
                     ((dr_r[1:0] == 2'd1) || (dr_r[1:0] == 2'd2));
        dtmcs_clear_s = upd_dr_s && (ir_r == IR_DTMCS) && (dr_r[16] || dr_r[17]);
        case (ir_r)
            IR_IDCODE: begin
                dr_capture_s = {{(DRW-32){1'b0}}, IDCODE};
                dr_shift_s   = {{(DRW-32){1'b0}}, tdi_sync_r, dr_r[31:1]};
            end
            IR_DTMCS: begin
                dr_capture_s = {{(DRW-32){1'b0}}, 14'd0, 1'b0, 1'b0, 1'b0, 3'd1,
                                dmistat_r, 6'(ABITS), 4'd1};
                dr_shift_s   = {{(DRW-32){1'b0}}, tdi_sync_r, dr_r[31:1]};
            end
            IR_DMI: begin
                dr_capture_s = {dmi_addr_r, rdata_buf_r, busy_r ? 2'd3 : dmistat_r};
                dr_shift_s   = {tdi_sync_r, dr_r[DRW-1:1]};
            end
            default: begin
                dr_capture_s = {DRW{1'b0}};
                dr_shift_s   = {{(DRW-1){1'b0}}, tdi_sync_r};
            end
        endcase
    end

    // TAP controller: state walk, IR/DR capture-shift-update and tdo on the falling edge
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= TLR;
            ir_r       <= IR_IDCODE;
            ir_shift_r <= 5'd0;
            dr_r       <= {DRW{1'b0}};
            tdo_r      <= 1'b0;
        end else begin
            if (tck_rise_s) begin
                state_r <= tap_next(state_r, tms_sync_r);
                case (state_r)
                    TLR:     ir_r       <= IR_IDCODE;
                    CAP_IR:  ir_shift_r <= 5'b00001;
                    SH_IR:   ir_shift_r <= {tdi_sync_r, ir_shift_r[4:1]};
                    UPD_IR:  ir_r       <= ir_shift_r;
                    CAP_DR:  dr_r       <= dr_capture_s;
                    SH_DR:   dr_r       <= dr_shift_s;
                    default: ir_r       <= ir_r;
                endcase
            end
            // tdo changes only on falling edges inside a shift state, holding otherwise
            if (tck_fall_s && (state_r == SH_DR)) begin
                tdo_r <= dr_r[0];
            end else if (tck_fall_s && (state_r == SH_IR)) begin
                tdo_r <= ir_shift_r[0];
            end else begin
                tdo_r <= tdo_r;
            end
        end
    end

    // DMI initiator: request launch, handshake completion and sticky error status
    always_ff @(posedge clk) begin
        if (reset) begin
            dmi_valid_r <= 1'b0;
            dmi_write_r <= 1'b0;
            dmi_addr_r  <= '0;
            dmi_wdata_r <= 32'd0;
            busy_r      <= 1'b0;
            dmistat_r   <= 2'd0;
            rdata_buf_r <= 32'd0;
        end else begin
            if (dmi_valid_r && dmi_ready) begin
                dmi_valid_r <= 1'b0;
                busy_r      <= 1'b0;
                if (!dmi_write_r) begin
                    rdata_buf_r <= dmi_rdata;
                end
            end
            // busy_r is still set in the handshake cycle, so a colliding request counts as a busy hit
            if (dmi_req_s) begin
                if (busy_r) begin
                    dmistat_r <= 2'd3;
                end else if (dmistat_r == 2'd0) begin
                    dmi_valid_r <= 1'b1;
                    busy_r      <= 1'b1;
                    dmi_addr_r  <= dr_r[DRW-1:34];
                    dmi_wdata_r <= dr_r[33:2];
                    dmi_write_r <= (dr_r[1:0] == 2'd2);
                end
            end
            if (dtmcs_clear_s) begin
                dmistat_r <= 2'd0;
            end
        end
    end

    assign tdo       = tdo_r;
    assign dmi_valid = dmi_valid_r;
    assign dmi_write = dmi_write_r;
    assign dmi_addr  = dmi_addr_r;
    assign dmi_wdata = dmi_wdata_r;

endmodule

// File: tb/tb_dm_jtag_dtm.sv
// Directed bench for dm_jtag_dtm: bit-banged JTAG scans against a dm-like DMI responder.
module tb_dm_jtag_dtm;

    logic        clk = 1'b0;
    logic        reset;
    logic        tck, tms, tdi, tdo;
    logic        dmi_valid, dmi_ready, dmi_write;
    logic [6:0]  dmi_addr;
    logic [31:0] dmi_wdata, dmi_rdata;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] mem [128];
    bit          hold_ready = 1'b0;
    int          wait_cnt = 0;
    int          xfers = 0;
    int          valid_cycles = 0;
    logic        last_write;
    logic [6:0]  last_addr;
    logic [31:0] last_wdata;
    logic [4:0]  ir_out;
    logic [40:0] dout;

    dm_jtag_dtm dut (
        .clk       (clk),
        .reset     (reset),
        .tck       (tck),
        .tms       (tms),
        .tdi       (tdi),
        .tdo       (tdo),
        .dmi_valid (dmi_valid),
        .dmi_ready (dmi_ready),
        .dmi_write (dmi_write),
        .dmi_addr  (dmi_addr),
        .dmi_wdata (dmi_wdata),
        .dmi_rdata (dmi_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // dm-like responder: ready one clk after valid is seen, transfer committed when ready rises
    always @(negedge clk) begin
        if (dmi_valid === 1'b1) valid_cycles++;
        if (dmi_valid === 1'b1 && dmi_ready == 1'b0 && !hold_ready) begin
            if (wait_cnt != 0) begin
                dmi_ready  = 1'b1;
                dmi_rdata  = mem[dmi_addr];
                xfers++;
                last_write = dmi_write;
                last_addr  = dmi_addr;
                last_wdata = dmi_wdata;
                if (dmi_write) mem[dmi_addr] = dmi_wdata;
            end else begin
                wait_cnt = 1;
            end
        end else begin
            dmi_ready = 1'b0;
            wait_cnt  = 0;
        end
    end

    task automatic pulse(input logic m, input logic d, output logic o);
        tms = m;
        tdi = d;
        #50;
        o = tdo;
        tck = 1'b1;
        #50;
        tck = 1'b0;
    endtask

    task automatic tap_reset();
        logic o;
        for (int i = 0; i < 5; i++) pulse(1'b1, 1'b0, o);
        pulse(1'b0, 1'b0, o);
    endtask

    task automatic shift_ir(input logic [4:0] v, output logic [4:0] q);
        logic o;
        pulse(1'b1, 1'b0, o);
        pulse(1'b1, 1'b0, o);
        pulse(1'b0, 1'b0, o);
        pulse(1'b0, 1'b0, o);
        for (int i = 0; i < 5; i++) begin
            pulse(i == 4, v[i], o);
            q[i] = o;
        end
        pulse(1'b1, 1'b0, o);
        pulse(1'b0, 1'b0, o);
    endtask

    task automatic shift_dr(input logic [40:0] din, input int len, output logic [40:0] q);
        logic o;
        q = 41'd0;
        pulse(1'b1, 1'b0, o);
        pulse(1'b0, 1'b0, o);
        pulse(1'b0, 1'b0, o);
        for (int i = 0; i < len; i++) begin
            pulse(i == len - 1, din[i], o);
            q[i] = o;
        end
        pulse(1'b1, 1'b0, o);
        pulse(1'b0, 1'b0, o);
        repeat (20) @(negedge clk);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 128; i++) mem[i] = 32'd0;
        reset = 1'b1;
        tck = 1'b0;
        tms = 1'b1;
        tdi = 1'b0;
        dmi_ready = 1'b0;
        dmi_rdata = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_tdo", tdo, 1'b0);
        chk("rst_valid", dmi_valid, 1'b0);
        chk("rst_write", dmi_write, 1'b0);
        chk("rst_addr", dmi_addr, 7'd0);
        chk("rst_wdata", dmi_wdata, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // IDCODE is selected out of Test-Logic-Reset
        tap_reset();
        shift_dr(41'd0, 32, dout);
        chk("idcode", dout[31:0], 32'h1000_0A6D);

        shift_ir(5'h10, ir_out);
        chk("ir_capture", ir_out, 5'b00001);
        shift_dr(41'd0, 32, dout);
        chk("dtmcs", dout[31:0], 32'h0000_1071);

        // DMI write of 0xDEADBEEF to word 4
        shift_ir(5'h11, ir_out);
        valid_cycles = 0;
        shift_dr({7'h04, 32'hDEAD_BEEF, 2'd2}, 41, dout);
        chk("wr_capture", dout, 41'd0);
        chk("wr_xfers", xfers, 1);
        chk("wr_write", last_write, 1'b1);
        chk("wr_addr", last_addr, 7'h04);
        chk("wr_wdata", last_wdata, 32'hDEAD_BEEF);
        chk("wr_valid_cycles", valid_cycles, 2);

        // read back word 4, then a nop scan returns the data
        valid_cycles = 0;
        shift_dr({7'h04, 32'h0, 2'd1}, 41, dout);
        chk("rd_capture", dout, {7'h04, 32'h0, 2'd0});
        chk("rd_xfers", xfers, 2);
        chk("rd_write", last_write, 1'b0);
        chk("rd_valid_cycles", valid_cycles, 2);
        shift_dr(41'd0, 41, dout);
        chk("nop_data", dout[33:2], 32'hDEAD_BEEF);
        chk("nop_op", dout[1:0], 2'd0);
        chk("nop_addr", dout[40:34], 7'h04);

        // busy hit: second request while the first is stalled
        hold_ready = 1'b1;
        shift_dr({7'h04, 32'h0, 2'd1}, 41, dout);
        chk("busy_first_op", dout[1:0], 2'd0);
        shift_dr({7'h05, 32'h0, 2'd1}, 41, dout);
        chk("busy_second_op", dout[1:0], 2'd3);
        chk("busy_held_xfers", xfers, 2);
        hold_ready = 1'b0;
        repeat (20) @(negedge clk);
        chk("busy_done_xfers", xfers, 3);
        chk("busy_addr", last_addr, 7'h04);
        shift_dr(41'd0, 41, dout);
        chk("sticky_op", dout[1:0], 2'd3);
        shift_dr(41'd0, 41, dout);
        chk("sticky_xfers", xfers, 3);
        shift_ir(5'h10, ir_out);
        shift_dr(41'h1_0000, 32, dout);
        chk("dtmcs_sticky", dout[31:0], 32'h0000_1C71);
        shift_ir(5'h11, ir_out);
        shift_dr(41'd0, 41, dout);
        chk("cleared_op", dout[1:0], 2'd0);

        // reset during a stalled transaction
        hold_ready = 1'b1;
        shift_dr({7'h06, 32'h0, 2'd1}, 41, dout);
        n = 0;
        while (dmi_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("pre_reset_valid", dmi_valid, 1'b1);
        shift_dr({7'h07, 32'h0, 2'd1}, 41, dout);
        chk("pre_reset_op", dout[1:0], 2'd3);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_reset_valid", dmi_valid, 1'b0);
        chk("mid_reset_addr", dmi_addr, 7'd0);
        @(negedge clk);
        reset = 1'b0;
        hold_ready = 1'b0;
        repeat (2) @(negedge clk);
        tap_reset();
        shift_dr(41'd0, 32, dout);
        chk("post_reset_idcode", dout[31:0], 32'h1000_0A6D);
        shift_ir(5'h11, ir_out);
        shift_dr(41'd0, 41, dout);
        chk("post_reset_dmi", dout, 41'd0);
        chk("post_reset_xfers", xfers, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
